hex_display_ctrl: RTL and testbench

Display controller for the six DE10-Lite HEX digits. Holds a six-entry digit file (value, blank, blink), written by the lock FSM through a one-cycle write strobe. Shares a single `sevenseg` decoder by round-robin scanning one digit per clock. Registers each decoded pattern into that digit's HEX output and applies decimal-point, blank and blink control.

---
 rtl/display_pkg.sv | 16 +
 rtl/sevenseg.sv | 30 +++
 rtl/hex_display_ctrl.sv | 99 +++++++++
 tb/tb_hex_display_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the six-digit HEX display controller.
package display_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       blink;
  } digit_entry_t;

  // Power-up / cleared entry: digit dark, not blinking.
  localparam digit_entry_t ENTRY_RESET = '{value: 4'h0, blank: 1'b1, blink: 1'b0};
endpackage

// File: rtl/sevenseg.sv
// Hex nibble to active-low seven-segment pattern, bit order g..a.
module sevenseg (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure combinational lookup of the glyph for each nibble.
  always_comb begin
    seg = 7'h7F;
    unique case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Six-digit HEX display controller: digit file, round-robin scan through a
// single shared decoder, per-digit output registers, and a blink timer.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  wr_blank,
  input  logic                  wr_blink,
  input  logic [NUM_DIGITS-1:0] dp,
  output logic [7:0]            hex0,
  output logic [7:0]            hex1,
  output logic [7:0]            hex2,
  output logic [7:0]            hex3,
  output logic [7:0]            hex4,
  output logic [7:0]            hex5,
  output logic                  refresh_done
);
  import display_pkg::*;

  localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam digit_idx_t       LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  digit_entry_t     file_q [NUM_DIGITS];
  digit_idx_t       scan_ptr;
  logic [3:0]       scan_value;
  logic [6:0]       seg;
  logic [7:0]       hex_p0 [NUM_DIGITS];
  logic             done_p0;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // Final output byte for one digit: blanked, blink-hidden, or glyph plus DP.
  function automatic logic [7:0] compose(input digit_entry_t e, input logic phase,
                                         input logic dp_bit, input logic [6:0] s);
    if (e.blank || (e.blink && phase))
      return SEG_BLANK;
    return {~dp_bit, s};
  endfunction

  assign scan_value = file_q[scan_ptr].value;

  sevenseg u_dec (
    .value (scan_value),
    .seg   (seg)
  );

  // Digit file: clear beats write; out-of-range indices are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) file_q[i] <= ENTRY_RESET;
    end else if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) file_q[i] <= ENTRY_RESET;
    end else if (wr_en && (wr_idx <= LAST_IDX)) begin
      file_q[wr_idx] <= '{value: wr_data, blank: wr_blank, blink: wr_blink};
    end
  end

  // Stage p0: scan one digit per clock into its output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_ptr <= '0;
      done_p0  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hex_p0[i] <= SEG_BLANK;
    end else begin
      hex_p0[scan_ptr] <= compose(file_q[scan_ptr], blink_phase, dp[scan_ptr], seg);
      done_p0          <= (scan_ptr == LAST_IDX);
      scan_ptr         <= (scan_ptr == LAST_IDX) ? '0 : scan_ptr + 3'd1;
    end
  end

  // Blink timer: phase flips each time the divider wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign hex0         = hex_p0[0];
  assign hex1         = hex_p0[1];
  assign hex2         = hex_p0[2];
  assign hex3         = hex_p0[3];
  assign hex4         = hex_p0[4];
  assign hex5         = hex_p0[5];
  assign refresh_done = done_p0;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl with a cycle-count based reference model.
module tb_hex_display_ctrl;
  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       reset, clr, wr_en, wr_blank, wr_blink;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic [5:0] dp;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       refresh_done;
  logic [7:0] hx [6];

  int checks = 0;
  int errors = 0;

  // Reference state: digit file contents, expected outputs, edges since reset.
  logic [3:0] m_val   [6];
  bit         m_blank [6];
  bit         m_blink [6];
  logic [7:0] m_hex   [6];
  bit         m_done;
  int         k;
  bit         seen_on, seen_off;

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_blank(wr_blank), .wr_blink(wr_blink), .dp(dp),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .refresh_done(refresh_done)
  );

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_val[i] = 4'h0; m_blank[i] = 1'b1; m_blink[i] = 1'b0; m_hex[i] = 8'hFF;
    end
    m_done = 1'b0;
    k = 0;
  endtask

  // Edge number k+1 after reset refreshes digit k mod 6 with the blink phase
  // implied by how many full divider periods have elapsed.
  task automatic model_edge();
    int  d;
    bit  phase;
    d     = k % 6;
    phase = ((k / BDIV) % 2) == 1;
    if (m_blank[d] || (m_blink[d] && phase)) m_hex[d] = 8'hFF;
    else                                     m_hex[d] = {~dp[d], ref_seg(m_val[d])};
    m_done = ((k + 1) % 6) == 0;
    if (clr) begin
      for (int i = 0; i < 6; i++) begin
        m_val[i] = 4'h0; m_blank[i] = 1'b1; m_blink[i] = 1'b0;
      end
    end else if (wr_en && wr_idx < 3'd6) begin
      m_val[wr_idx] = wr_data; m_blank[wr_idx] = wr_blank; m_blink[wr_idx] = wr_blink;
    end
    k++;
  endtask

  task automatic check_all();
    for (int d = 0; d < 6; d++) begin
      checks++;
      assert (hx[d] === m_hex[d]) else begin
        errors++;
        $error("FAIL hex%0d observed=%h expected=%h edge=%0d", d, hx[d], m_hex[d], k);
      end
    end
    checks++;
    assert (refresh_done === m_done) else begin
      errors++;
      $error("FAIL refresh_done observed=%b expected=%b edge=%0d", refresh_done, m_done, k);
    end
  endtask

  task automatic spot(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic set_write(input bit en, input logic [2:0] idx, input logic [3:0] data,
                           input bit blank, input bit blink);
    wr_en = en; wr_idx = idx; wr_data = data; wr_blank = blank; wr_blink = blink;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; dp = 6'h00;
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    model_reset();

    // Power-up reset, then twelve cycles of blank scanning.
    tick(); tick();
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (n == 5 || n == 11) spot("refresh_pulse", {7'd0, refresh_done}, 8'd1);
    end

    // Write latency, then live decimal point.
    set_write(1, 3'd2, 4'h3, 1'b0, 1'b0);
    tick();
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (6) tick();
    spot("hex2_dp_off", hex2, 8'hB0);
    dp = 6'b000100;
    repeat (6) tick();
    spot("hex2_dp_on", hex2, 8'h30);
    dp = 6'h00;

    // Ignored indices.
    set_write(1, 3'd6, 4'h8, 1'b0, 1'b0);
    tick();
    set_write(1, 3'd7, 4'h9, 1'b0, 1'b0);
    tick();
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (6) tick();

    // Clear wins over a simultaneous write.
    clr = 1'b1;
    set_write(1, 3'd0, 4'h5, 1'b0, 1'b0);
    tick();
    clr = 1'b0;
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (6) tick();
    spot("clr_hex0", hex0, 8'hFF);
    spot("clr_hex2", hex2, 8'hFF);

    // Blinking digit 1 next to a steady digit 4.
    set_write(1, 3'd1, 4'h1, 1'b0, 1'b1);
    tick();
    set_write(1, 3'd4, 4'h4, 1'b0, 1'b0);
    tick();
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    seen_on = 1'b0; seen_off = 1'b0;
    for (int n = 0; n < 32; n++) begin
      tick();
      if (hex1 === 8'hF9) seen_on = 1'b1;
      if (hex1 === 8'hFF) seen_off = 1'b1;
    end
    spot("blink_seen_on", {7'd0, seen_on}, 8'd1);
    spot("blink_seen_off", {7'd0, seen_off}, 8'd1);

    // Back-to-back writes to every digit.
    for (int i = 0; i < 6; i++) begin
      set_write(1, 3'(i), 4'(i), 1'b0, 1'b0);
      tick();
    end
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (12) tick();
    spot("b2b_hex0", hex0, 8'hC0);
    spot("b2b_hex1", hex1, 8'hF9);
    spot("b2b_hex2", hex2, 8'hA4);
    spot("b2b_hex3", hex3, 8'hB0);
    spot("b2b_hex4", hex4, 8'h99);
    spot("b2b_hex5", hex5, 8'h92);

    // Asynchronous reset with the scan pointing at digit 3.
    for (int n = 0; n < 6 && (k % 6) != 3; n++) tick();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick(); tick();
    reset = 1'b0;
    set_write(1, 3'd0, 4'hA, 1'b0, 1'b0);
    tick();
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (6) tick();
    spot("post_reset_hex0", hex0, 8'h88);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      set_write($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      dp  = 6'($urandom_range(0, 63));
      clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr = 1'b0;
    set_write(0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
